// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the mem_lsu load/store unit: data width, request
// size encodings, FSM state type and the alignment helper.
package mem_lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 behaves as a word too

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  // Half at an odd address, or word (incl. size 11) off a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == SZ_HALF)  bad = addr_lo[0];
    else if (size[1])     bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Combinational data lane: merges store data into the captured RAM word for
// sub-word writes, and extracts / extends load data from the captured word.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] cap_word,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] ld_data
);

  // Size-dependent merge and extract; word (10/11) passes straight through.
  always_comb begin
    merged  = st_data;
    ld_data = cap_word;
    case (size)
      SZ_BYTE: begin
        merged  = {cap_word[31:8], st_data[7:0]};
        ld_data = {{24{is_signed & cap_word[7]}}, cap_word[7:0]};
      end
      SZ_HALF: begin
        merged  = {cap_word[31:16], st_data[15:0]};
        ld_data = {{16{is_signed & cap_word[15]}}, cap_word[15:0]};
      end
      default: begin
        merged  = st_data;
        ld_data = cap_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for a 32-bit little-endian dual-port RAM.
// One request at a time; sub-word stores are done as read-modify-write.
// Optional macro MEM_LSU_ALIGN_CHECK_EN: misaligned half/word requests are
// answered at once with resp_err=1 and no RAM access.
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so a busy unit leaves the request pending
// and the requester must hold it. resp_valid is a single-cycle pulse with no
// back-pressure.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 0
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr_r,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  // Wait counter reload: RD lasts RD_LAT+1 cycles (RD_LAT is 0 or 1).
  localparam logic RD_RELOAD = (RD_LAT != 0);

  state_e            state_q, state_d;
  logic              cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef MEM_LSU_ALIGN_CHECK_EN
  logic              err_q, err_d;
`endif

  logic [DATA_W-1:0] lane_cap;
  logic [DATA_W-1:0] lane_merged;
  logic [DATA_W-1:0] lane_ld;

  // In RD the lane sees live RAM data so the load result can be registered
  // straight into resp_rdata; in WR it merges against the captured word.
  assign lane_cap = (state_q == RD) ? mem_rdata : cap_q;

  mem_lsu_lane u_lane (
    .size     (size_q),
    .is_signed(signed_q),
    .cap_word (lane_cap),
    .st_data  (wdata_q),
    .merged   (lane_merged),
    .ld_data  (lane_ld)
  );

  // Next-state and datapath updates for the IDLE/RD/WR/RESP sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cap_d    = cap_q;
    rdata_d  = rdata_q;
`ifdef MEM_LSU_ALIGN_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
`ifdef MEM_LSU_ALIGN_CHECK_EN
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else
`endif
          if (req_we && req_size[1]) begin
            state_d = WR;
          end else begin
            state_d = RD;
            cnt_d   = RD_RELOAD;
          end
        end
      end
      RD: begin
        if (cnt_q == 1'b0) begin
          cap_d = mem_rdata;
          if (we_q) begin
            state_d = WR;
          end else begin
            state_d = RESP;
            rdata_d = lane_ld;
`ifdef MEM_LSU_ALIGN_CHECK_EN
            err_d   = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR: begin
        state_d = RESP;
        rdata_d = '0;
`ifdef MEM_LSU_ALIGN_CHECK_EN
        err_d   = 1'b0;
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset drops any pending operation.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q  <= IDLE;
      cnt_q    <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
`ifdef MEM_LSU_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
`ifdef MEM_LSU_ALIGN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  // Gated by reset so a WR or RESP cycle coinciding with reset has no effect.
  assign resp_valid = (state_q == RESP) && !p_reset;
  assign mem_we     = (state_q == WR) && !p_reset;
  assign mem_wdata  = mem_we ? lane_merged : '0;
  assign mem_addr_r = addr_q;
  assign mem_addr_w = addr_q;
  assign resp_rdata = rdata_q;
`ifdef MEM_LSU_ALIGN_CHECK_EN
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator that drives the byte-addressed, 32-bit, little-endian dual-port data RAM: read port `addr_r`/`rdata`, write port `addr_w`/`wdata`/`we`.
- Accepts one CPU-side request at a time: byte, halfword or word; load or store.
- Sub-word stores use a read-modify-write sequence, because the RAM always writes 4 bytes.
- Loads are extracted and sign- or zero-extended.
- Sits between the core's execute stage and the RAM.

Parameters:
- ADDR_W, 32, width of request and memory addresses.
- RD_LAT, 0, RAM read latency in cycles: 0 = combinational `rdata`, 1 = registered `rdata`. Only 0 and 1 are legal.

Ports:
- m_clock  in  1  clock; all state updates on the rising edge.
- p_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when `req_valid` && `req_ready`.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_signed  in  1  loads only: sign-extend when 1.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  error flag, qualified by `resp_valid`; tied 0 unless ALIGN_CHECK_EN.
- mem_addr_r  out  ADDR_W  RAM read address.
- mem_rdata  in  32  RAM read data; byte at `mem_addr_r` is bits [7:0].
- mem_addr_w  out  ADDR_W  RAM write address.
- mem_wdata  out  32  RAM write data.
- mem_we  out  1  RAM write enable.

Behaviour:
- FSM states: IDLE, RD, WR, RESP. `req_ready` = (state == IDLE).
- Accept cycle T: latch `req_we`, `req_size`, `req_signed`, `req_addr`, `req_wdata`.
- Transitions:
  - IDLE → RD for loads and sub-word stores.
  - IDLE → WR for word stores.
  - RD holds for RD_LAT+1 cycles; a wait counter reloads on entry.
  - On the last RD cycle `mem_rdata` is captured; then → RESP for loads, → WR for stores.
  - WR → RESP after exactly 1 cycle. RESP → IDLE after 1 cycle.
- Latency, accept to `resp_valid` (RD_LAT=0):
  - load: T+2
  - word store: T+2
  - byte/half store: T+3
  - Add RD_LAT wherever a RD state is used.
- `mem_addr_r` and `mem_addr_w` are both driven from the latched address in every state; the address is passed unmodified, with no alignment applied. Address wrap-around is the RAM's concern.
- `mem_we` = 1 only in WR.
- `mem_wdata` in WR:
  - word: latched wdata.
  - half: {captured[31:16], wdata[15:0]}.
  - byte: {captured[31:8], wdata[7:0]}.
- `mem_wdata` is 0 outside WR.
- Load extraction from the captured word:
  - byte: [7:0], extended to 32 bits by `req_signed`.
  - half: [15:0], extended to 32 bits by `req_signed`.
  - word: full word; `req_signed` ignored.
- `resp_rdata` is held until the next RESP. `resp_valid` is high only in RESP. There is no response back-pressure.
- A request arriving while busy is not accepted and must be held by the requester.
- Reset (any state, including mid-RMW):
  - state = IDLE, `mem_we` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - Latched request, `mem_addr_r`, `mem_addr_w` and `mem_wdata` are cleared to 0.
  - A pending operation is dropped with no response; a WR cycle coinciding with reset is suppressed.
  - `req_ready` = 1 in the first cycle after reset deasserts.

Optional Feature:
- Macro: MEM_LSU_ALIGN_CHECK_EN.
- Defined:
  - Half at an odd address, or word at an address with `addr[1:0]` != 0, goes IDLE → RESP directly at T+1.
  - No RAM access: `mem_we` stays 0.
  - `resp_err` = 1, `resp_rdata` = 0.
- Undefined: `resp_err` is tied 0 and misaligned accesses proceed normally.

Decomposition:
- Shared package `mem_lsu_pkg`:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state typedef: IDLE, RD, WR, RESP.
  - Data width constant 32.
- One sub-module, `mem_lsu_lane`: purely combinational store-merge and load-extract logic, with inputs (size, signed, captured word, store data).
- FSM and counters stay in `mem_lsu`.

Test Plan:
- RAM word @0x10 = 0x8899AABB; load byte signed @0x10 → `resp_valid` at T+2, `resp_rdata` = 0xFFFFFFBB; unsigned → 0x000000BB.
- Load half signed @0x12, RAM bytes 0x12=0x34, 0x13=0xF2 → `resp_rdata` = 0xFFFFF234; word load @0x10 → 0x8899AABB.
- RAM @0x20 = 0x11223344; store byte 0xA5 @0x20 → one `mem_we` pulse at T+2 with `mem_wdata` = 0x112233A5; word readback = 0x112233A5.
- Store word 0xDEADBEEF @0x40 → `mem_we` at T+1 only, `resp_valid` at T+2; `req_valid` held high during busy → next accept not before IDLE.
- Assert `p_reset` during RD of a half store → no `mem_we`, no `resp_valid`; RAM @addr unchanged; `req_ready` = 1 the cycle after reset drops.
- With MEM_LSU_ALIGN_CHECK_EN: word load @0x41 → `resp_err` = 1 at T+1, `mem_we` = 0; without the macro → normal load, `resp_err` = 0.
- RD_LAT=1 build: load latency becomes T+3; rerun the first scenario with identical data.
